// File: rtl/game_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_timer_pkg
// Purpose  : Shared types and constants for the game countdown controller:
//            round state encoding, BCD digit type, M:SS.t time record and
//            the saturation ceiling used by the bonus adder.
// Revision : 1.0 - initial release
// ============================================================================
package game_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } t_timer_state;

  typedef logic [3:0] t_bcd;

  typedef struct packed {
    t_bcd min;
    t_bcd sec_t;
    t_bcd sec_o;
    t_bcd tenth;
  } t_game_time;

  // Largest representable time, 9:59.9
  localparam t_game_time MAX_TIME = '{min: 4'd9, sec_t: 4'd5, sec_o: 4'd9, tenth: 4'd9};

endpackage
`default_nettype wire

// File: rtl/bcd_down_digit.sv
`default_nettype none
// ============================================================================
// Module   : bcd_down_digit
// Purpose  : One BCD digit of a down-counter. Wraps 0 -> MAX_VAL and raises
//            borrow_out combinationally when asked to step below zero, so
//            digits chain by feeding borrow_out into the next dec_in.
//            A load overrides any decrement in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_down_digit
  import game_timer_pkg::*;
#(
  parameter t_bcd MAX_VAL = 4'd9,
  parameter t_bcd RST_VAL = 4'd0
) (
  input  logic clk,
  input  logic resetN,
  input  logic dec_in,
  input  logic load,
  input  t_bcd load_val,
  output t_bcd q,
  output logic borrow_out
);

  t_bcd q_q;
  t_bcd q_d;

  // Next digit value: load wins, otherwise step down with wrap
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (dec_in) begin
      q_d = (q_q == 4'd0) ? MAX_VAL : q_q - 4'd1;
    end
  end

  // Digit register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetN) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q          = q_q;
  assign borrow_out = dec_in && (q_q == 4'd0);

endmodule
`default_nettype wire

// File: rtl/game_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_timer_ctrl
// Purpose  : Round countdown controller. Holds remaining time as BCD M:SS.t,
//            sequences IDLE/RUN/PAUSE/EXPIRED from tick and button pulses,
//            and drives the low-time warning and a one-cycle time_up pulse.
//            Optional feature macro: GAME_TIMER_BONUS_EN (adds add_bonus port
//            and a saturating seconds adder).
// Revision : 1.0 - initial release
// ============================================================================
module game_timer_ctrl
  import game_timer_pkg::*;
#(
  parameter int START_MIN = 2,
  parameter int START_SEC = 0,
  parameter int WARN_SEC  = 10,
  parameter int BONUS_SEC = 5
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       onetens_sec,
  input  logic       start,
  input  logic       pause_toggle,
  input  logic       restart,
`ifdef GAME_TIMER_BONUS_EN
  input  logic       add_bonus,
`endif
  output logic [3:0] min_d,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic [3:0] tenth_d,
  output logic       running,
  output logic       paused,
  output logic       expired,
  output logic       time_up,
  output logic       warning
);

  localparam t_game_time START_TIME = '{
    min:   t_bcd'(START_MIN),
    sec_t: t_bcd'(START_SEC / 10),
    sec_o: t_bcd'(START_SEC % 10),
    tenth: 4'd0
  };

  t_timer_state state_q, state_d;
  logic         time_up_q, time_up_d;

  t_game_time cur;
  t_game_time load_time;
  logic       pause_act, bonus_act, start_act, tick_act;
  logic       dec, load, is_zero, is_one;
  logic       b_tenth, b_sec_o, b_sec_t, b_min;
  logic [6:0] sec_total;

  wire active = (state_q == ST_RUN) || (state_q == ST_PAUSE);

`ifdef GAME_TIMER_BONUS_EN
  t_game_time bonus_time;
  logic [6:0] sec_sum, sec_wrap, tens7, ones7;
  logic [4:0] min_sum;
  logic       unused_bits;

  // Add BONUS_SEC to the seconds field, carry into minutes, clamp at 9:59.9
  always_comb begin
    sec_sum  = 7'(cur.sec_t) * 7'd10 + 7'(cur.sec_o) + 7'(BONUS_SEC);
    sec_wrap = sec_sum;
    min_sum  = 5'(cur.min);
    if (sec_sum >= 7'd60) begin
      sec_wrap = sec_sum - 7'd60;
      min_sum  = min_sum + 5'd1;
    end
    tens7 = sec_wrap / 7'd10;
    ones7 = sec_wrap % 7'd10;
    if (min_sum > 5'd9) begin
      bonus_time = MAX_TIME;
    end else begin
      bonus_time = '{min: min_sum[3:0], sec_t: tens7[3:0], sec_o: ones7[3:0], tenth: cur.tenth};
    end
  end

  assign unused_bits = ^{tens7[6:4], ones7[6:4]};
  assign bonus_act   = !restart && !pause_act && add_bonus && active;
  assign load_time   = restart ? START_TIME : bonus_time;
`else
  assign bonus_act   = 1'b0;
  assign load_time   = START_TIME;
`endif

  // Resolve the single event that acts this cycle, highest priority first
  always_comb begin
    pause_act = !restart && pause_toggle && active;
    start_act = !restart && start && (state_q == ST_IDLE);
    tick_act  = !restart && !pause_act && !bonus_act && onetens_sec && (state_q == ST_RUN);
    is_zero   = (cur == '0);
    is_one    = (cur.min == 4'd0) && (cur.sec_t == 4'd0) && (cur.sec_o == 4'd0) && (cur.tenth == 4'd1);
    dec       = tick_act && !is_zero;
    load      = restart || bonus_act;
  end

  // Round state and the registered expiry pulse
  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = ST_IDLE;
    end else if (pause_act) begin
      state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
    end else if (start_act) begin
      state_d = ST_RUN;
    end else if (tick_act && (is_zero || is_one)) begin
      state_d = ST_EXPIRED;
    end
    time_up_d = (state_d == ST_EXPIRED) && (state_q != ST_EXPIRED);
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q   <= ST_IDLE;
      time_up_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_up_q <= time_up_d;
    end
  end

  bcd_down_digit #(.MAX_VAL(4'd9), .RST_VAL(START_TIME.tenth)) u_tenth (
    .clk(clk), .resetN(resetN), .dec_in(dec), .load(load),
    .load_val(load_time.tenth), .q(cur.tenth), .borrow_out(b_tenth));

  bcd_down_digit #(.MAX_VAL(4'd9), .RST_VAL(START_TIME.sec_o)) u_sec_o (
    .clk(clk), .resetN(resetN), .dec_in(b_tenth), .load(load),
    .load_val(load_time.sec_o), .q(cur.sec_o), .borrow_out(b_sec_o));

  bcd_down_digit #(.MAX_VAL(4'd5), .RST_VAL(START_TIME.sec_t)) u_sec_t (
    .clk(clk), .resetN(resetN), .dec_in(b_sec_o), .load(load),
    .load_val(load_time.sec_t), .q(cur.sec_t), .borrow_out(b_sec_t));

  bcd_down_digit #(.MAX_VAL(4'd9), .RST_VAL(START_TIME.min)) u_min (
    .clk(clk), .resetN(resetN), .dec_in(b_sec_t), .load(load),
    .load_val(load_time.min), .q(cur.min), .borrow_out(b_min));

  // Minutes never borrow because a decrement is suppressed at 0:00.0
  logic unused_borrow;
  assign unused_borrow = b_min;

  assign sec_total = 7'(cur.sec_t) * 7'd10 + 7'(cur.sec_o);
  assign warning   = active && (cur.min == 4'd0) && (sec_total < 7'(WARN_SEC));

  assign min_d   = cur.min;
  assign sec_t   = cur.sec_t;
  assign sec_o   = cur.sec_o;
  assign tenth_d = cur.tenth;
  assign running = (state_q == ST_RUN);
  assign paused  = (state_q == ST_PAUSE);
  assign expired = (state_q == ST_EXPIRED);
  assign time_up = time_up_q;

endmodule
`default_nettype wire

// File: tb/tb_game_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_timer_ctrl
// Purpose  : Self-checking bench for game_timer_ctrl. A reference model keeps
//            the remaining time as an integer count of tenths and the round
//            phase as a small integer; every cycle all outputs are compared.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_timer_ctrl;

  localparam int START_MIN = 2;
  localparam int START_SEC = 0;
  localparam int WARN_SEC  = 10;
  localparam int BONUS_SEC = 5;
  localparam int START_T   = START_MIN * 600 + START_SEC * 10;
  localparam int MAX_T     = 5999;
`ifdef GAME_TIMER_BONUS_EN
  localparam bit BONUS_ON = 1'b1;
`else
  localparam bit BONUS_ON = 1'b0;
`endif

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       onetens_sec = 1'b0, start = 1'b0, pause_toggle = 1'b0, restart = 1'b0, add_bonus = 1'b0;
  logic [3:0] min_d, sec_t, sec_o, tenth_d;
  logic       running, paused, expired, time_up, warning;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model
  int m_t     = START_T;
  int m_state = M_IDLE;
  bit m_tu    = 1'b0;

  always #5 clk = ~clk;

  game_timer_ctrl #(
    .START_MIN(START_MIN), .START_SEC(START_SEC), .WARN_SEC(WARN_SEC), .BONUS_SEC(BONUS_SEC)
  ) dut (
    .clk(clk), .resetN(resetN), .onetens_sec(onetens_sec), .start(start),
    .pause_toggle(pause_toggle), .restart(restart),
`ifdef GAME_TIMER_BONUS_EN
    .add_bonus(add_bonus),
`endif
    .min_d(min_d), .sec_t(sec_t), .sec_o(sec_o), .tenth_d(tenth_d),
    .running(running), .paused(paused), .expired(expired),
    .time_up(time_up), .warning(warning)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int add_bonus_t(input int t);
    int s;
    s = t + BONUS_SEC * 10;
    return (s > MAX_T) ? MAX_T : s;
  endfunction

  // Advance the model by one clock edge using the sampled inputs
  task automatic model_step(input bit r, input bit p, input bit b, input bit s, input bit tk);
    int prev;
    prev = m_state;
    if (!resetN) begin
      m_t = START_T; m_state = M_IDLE; m_tu = 1'b0;
      return;
    end
    if (r) begin
      m_t = START_T; m_state = M_IDLE;
    end else begin
      case (m_state)
        M_IDLE:  if (s) m_state = M_RUN;
        M_RUN: begin
          if (p) m_state = M_PAUSE;
          else if (b && BONUS_ON) m_t = add_bonus_t(m_t);
          else if (tk) begin
            if (m_t > 0) m_t = m_t - 1;
            if (m_t == 0) m_state = M_EXP;
          end
        end
        M_PAUSE: begin
          if (p) m_state = M_RUN;
          else if (b && BONUS_ON) m_t = add_bonus_t(m_t);
        end
        default: ;
      endcase
    end
    m_tu = (m_state == M_EXP) && (prev != M_EXP);
  endtask

  task automatic check_all(input string tag);
    bit act;
    act = (m_state == M_RUN) || (m_state == M_PAUSE);
    check({tag, ".min"},   int'(min_d),   m_t / 600);
    check({tag, ".sec_t"}, int'(sec_t),   ((m_t / 10) % 60) / 10);
    check({tag, ".sec_o"}, int'(sec_o),   (m_t / 10) % 10);
    check({tag, ".tenth"}, int'(tenth_d), m_t % 10);
    check({tag, ".running"}, int'(running), int'(m_state == M_RUN));
    check({tag, ".paused"},  int'(paused),  int'(m_state == M_PAUSE));
    check({tag, ".expired"}, int'(expired), int'(m_state == M_EXP));
    check({tag, ".time_up"}, int'(time_up), int'(m_tu));
    check({tag, ".warning"}, int'(warning), int'(act && (m_t < 600) && ((m_t / 10) < WARN_SEC)));
  endtask

  task automatic step(input string tag, input bit r, input bit p, input bit b, input bit s, input bit tk);
    restart = r; pause_toggle = p; add_bonus = b; start = s; onetens_sec = tk;
    @(posedge clk);
    model_step(r, p, b, s, tk);
    #1;
    check_all(tag);
  endtask

  // Tick until the model reaches the target time; bounded by a cycle budget
  task automatic run_to(input string tag, input int target);
    int budget;
    budget = 7000;
    while (m_t != target && budget > 0) begin
      step(tag, 0, 0, 0, 0, 1);
      budget--;
    end
    check({tag, ".reached"}, m_t, target);
  endtask

  initial begin
    // Reset with random noise on the inputs
    for (int i = 0; i < 3; i++) begin
      step("reset", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    resetN = 1'b1;
    step("idle_tick", 0, 0, 0, 0, 1);

    // Full round to expiry, then observe the pulse dropping
    step("start", 0, 0, 0, 1, 0);
    run_to("countdown", 99);
    run_to("warn_zone", 0);
    for (int i = 0; i < 4; i++) step("exp_hold", 0, 1, 1, 1, 1);

    // restart in EXPIRED, then restart with start in IDLE
    step("restart_exp", 1, 0, 0, 0, 0);
    step("restart_start", 1, 0, 0, 1, 0);
    step("start2", 0, 0, 0, 1, 0);

    // Pause behaviour at 0:45.3
    run_to("to_453", 453);
    step("pause", 0, 1, 0, 0, 0);
    for (int i = 0; i < 30; i++) step("paused_ticks", 0, 0, 0, 0, 1);
    step("resume", 0, 1, 0, 0, 0);
    step("resume_tick", 0, 0, 0, 0, 1);

    // Tick and pause together at 0:30.0
    run_to("to_300", 300);
    step("tick_pause", 0, 1, 0, 0, 1);
    step("unpause", 0, 1, 0, 0, 0);

    // Restart on the cycle time_up is high
    run_to("to_exp2", 0);
    step("restart_on_tu", 1, 0, 0, 0, 0);

    // Bonus: bonus ignored in IDLE, carry into minutes, saturation, tick drop
    step("bonus_idle", 0, 0, 1, 0, 0);
    step("start3", 0, 0, 0, 1, 0);
    run_to("to_587", 587);
    step("bonus_carry", 0, 0, 1, 0, 1);
    step("pause_b", 0, 1, 0, 0, 0);
    step("bonus_paused", 0, 0, 1, 0, 1);
    step("unpause_b", 0, 1, 0, 0, 0);
    for (int i = 0; i < 130; i++) step("bonus_pile", 0, 0, 1, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int rr;
      bit r, p, b, s, tk;
      rr = $urandom_range(0, 999);
      resetN = (rr < 3) ? 1'b0 : 1'b1;
      r  = ($urandom_range(0, 199) == 0);
      p  = ($urandom_range(0, 39) == 0);
      b  = ($urandom_range(0, 29) == 0);
      s  = ($urandom_range(0, 9) == 0);
      tk = ($urandom_range(0, 3) != 0);
      step("random", r, p, b, s, tk);
    end
    resetN = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
